// File: rtl/pwr_supply_clk_ctrl_pkg.sv
// Shared constants for the supply clock controller: board-level channel count,
// timing defaults and a counter-width helper.
package pwr_supply_clk_ctrl_pkg;

    // X4xx CPLD board: number of switching supplies fed from this block.
    localparam int NUM_SUPPLIES_DEFAULT   = 3;
    localparam int STAGGER_CYCLES_DEFAULT = 100_000;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4_000;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int ctr_width(input int max_val);
        int w;
        w = (max_val < 1) ? 1 : $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pwr_supply_clk_monitor.sv
// Per-channel source clock monitor: registers the divided clock, detects its
// edges and raises a sticky fault when it stops toggling while requested.
module pwr_supply_clk_monitor
    import pwr_supply_clk_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic src_clk_in,
    input  logic enable_req,
    output logic fall,
    output logic fault,
    output logic fault_next
);

    localparam int               WDW    = ctr_width(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0]   WD_MAX = WDW'(TIMEOUT_CYCLES);

    logic           src_d_q;
    logic           src_d_d;
    logic           edge_det;
    logic [WDW-1:0] wd_q;
    logic [WDW-1:0] wd_d;
    logic           fault_q;
    logic           fault_d;

    always_comb begin
        src_d_d  = src_clk_in;
        edge_det = src_d_q ^ src_clk_in;
        fall     = src_d_q & ~src_clk_in;

        // Watchdog only runs while the channel is requested; it saturates.
        wd_d = wd_q;
        if (!enable_req || edge_det) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WDW'(1);
        end

        fault_d = enable_req & (fault_q | (wd_d == WD_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_d_q <= 1'b0;
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            src_d_q <= src_d_d;
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    assign fault      = fault_q;
    assign fault_next = fault_d;

endmodule

// File: rtl/pwr_supply_clk_ctrl.sv
// Glitch-free gating of divided supply clocks with staggered turn-on and a
// per-channel stopped-clock watchdog.
module pwr_supply_clk_ctrl
    import pwr_supply_clk_ctrl_pkg::*;
#(
    parameter int NUM_SUPPLIES   = NUM_SUPPLIES_DEFAULT,
    parameter int STAGGER_CYCLES = STAGGER_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SUPPLIES-1:0] src_clk_in,
    input  logic [NUM_SUPPLIES-1:0] enable_req,
    output logic [NUM_SUPPLIES-1:0] pwr_supply_clk,
    output logic [NUM_SUPPLIES-1:0] clk_enabled,
    output logic [NUM_SUPPLIES-1:0] clk_fault,
    output logic                    busy
);

    localparam int            IW         = (NUM_SUPPLIES > 1) ? $clog2(NUM_SUPPLIES) : 1;
    localparam int            SW         = ctr_width(STAGGER_CYCLES);
    localparam logic [SW-1:0] STAGGER_LD = SW'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_STAGGER
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           arm_idx_q, arm_idx_d;
    logic [SW-1:0]           stg_cnt_q, stg_cnt_d;
    logic                    busy_q, busy_d;
    logic [NUM_SUPPLIES-1:0] gate_q, gate_d;
    logic [NUM_SUPPLIES-1:0] pwr_q, pwr_d;

    logic [NUM_SUPPLIES-1:0] fall;
    logic [NUM_SUPPLIES-1:0] fault_next;
    logic [NUM_SUPPLIES-1:0] arm_fire;
    logic                    pick_found;
    logic [IW-1:0]           pick_idx;

    generate
        for (genvar gi = 0; gi < NUM_SUPPLIES; gi++) begin : g_mon
            pwr_supply_clk_monitor #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_mon (
                .clk        (clk),
                .rst        (rst),
                .src_clk_in (src_clk_in[gi]),
                .enable_req (enable_req[gi]),
                .fall       (fall[gi]),
                .fault      (clk_fault[gi]),
                .fault_next (fault_next[gi])
            );
        end
    endgenerate

    // Sequencer: one channel armed at a time, then a stagger hold-off.
    always_comb begin
        state_d    = state_q;
        arm_idx_d  = arm_idx_q;
        stg_cnt_d  = stg_cnt_q;
        arm_fire   = '0;
        pick_found = 1'b0;
        pick_idx   = '0;

        for (int i = NUM_SUPPLIES - 1; i >= 0; i--) begin
            if (enable_req[i] && !gate_q[i] && !clk_fault[i]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d   = ST_ARM;
                    arm_idx_d = pick_idx;
                end
            end
            ST_ARM: begin
                if (!enable_req[arm_idx_q] || fault_next[arm_idx_q]) begin
                    state_d = ST_IDLE;
                end else if (fall[arm_idx_q]) begin
                    arm_fire[arm_idx_q] = 1'b1;
                    stg_cnt_d           = STAGGER_LD;
                    state_d             = ST_STAGGER;
                end
            end
            ST_STAGGER: begin
                if (stg_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    stg_cnt_d = stg_cnt_q - SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Gates move only on a source falling edge, so the output never gets a
    // runt pulse; a fault overrides and clears the gate immediately.
    always_comb begin
        gate_d = gate_q;
        for (int i = 0; i < NUM_SUPPLIES; i++) begin
            if (fall[i]) begin
                if (arm_fire[i]) begin
                    gate_d[i] = 1'b1;
                end else if (!enable_req[i]) begin
                    gate_d[i] = 1'b0;
                end
            end
            if (fault_next[i]) begin
                gate_d[i] = 1'b0;
            end
        end
        pwr_d = src_clk_in & gate_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            arm_idx_q <= '0;
            stg_cnt_q <= '0;
            busy_q    <= 1'b0;
            gate_q    <= '0;
            pwr_q     <= '0;
        end else begin
            state_q   <= state_d;
            arm_idx_q <= arm_idx_d;
            stg_cnt_q <= stg_cnt_d;
            busy_q    <= busy_d;
            gate_q    <= gate_d;
            pwr_q     <= pwr_d;
        end
    end

    assign pwr_supply_clk = pwr_q;
    assign clk_enabled    = gate_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pwr_supply_clk_ctrl.sv
// Directed bench for pwr_supply_clk_ctrl: sources toggle every 10 clk with
// per-channel phase offsets; pulse widths and turn-on times are monitored.
module tb_pwr_supply_clk_ctrl;

    localparam int N   = 3;
    localparam int STG = 16;
    localparam int TMO = 40;

    logic         clk;
    logic         rst;
    logic [N-1:0] src_clk_in;
    logic [N-1:0] enable_req;
    logic [N-1:0] pwr_supply_clk;
    logic [N-1:0] clk_enabled;
    logic [N-1:0] clk_fault;
    logic         busy;

    logic [N-1:0] hold;
    int           n_cmp;
    int           n_err;
    int           cyc;
    int           hcnt[N];
    int           on_time[N];
    logic [N-1:0] en_prev;

    pwr_supply_clk_ctrl #(
        .NUM_SUPPLIES   (N),
        .STAGGER_CYCLES (STG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_clk_in     (src_clk_in),
        .enable_req     (enable_req),
        .pwr_supply_clk (pwr_supply_clk),
        .clk_enabled    (clk_enabled),
        .clk_fault      (clk_fault),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Source generator: each channel toggles every 10 clk unless held.
    initial begin
        int pc[N];
        src_clk_in = '0;
        for (int i = 0; i < N; i++) pc[i] = i * 3;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    if (pc[i] == 9) begin
                        pc[i] = 0;
                        src_clk_in[i] = ~src_clk_in[i];
                    end else begin
                        pc[i]++;
                    end
                end
            end
        end
    end

    // Output monitor: every completed high pulse must be 10 cycles wide.
    initial begin
        cyc = 0;
        en_prev = '0;
        for (int i = 0; i < N; i++) begin
            hcnt[i] = 0;
            on_time[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    hcnt[i] = 0;
                end else if (pwr_supply_clk[i]) begin
                    hcnt[i]++;
                end else if (hcnt[i] != 0) begin
                    check($sformatf("pulse_width_ch%0d", i), hcnt[i], 10);
                    hcnt[i] = 0;
                end
                if (clk_enabled[i] && !en_prev[i]) on_time[i] = cyc;
            end
            en_prev = clk_enabled;
        end
    end

    task automatic wait_src_fall(input int ch);
        logic prev;
        bit   seen;
        prev = src_clk_in[ch];
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (prev && !src_clk_in[ch]) seen = 1;
            prev = src_clk_in[ch];
        end
        if (!seen) check($sformatf("wait_src_fall_ch%0d", ch), 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic sp, op, hit;
        int   rises, last_rise, rise_k, busy_gate, hc, cnt, bcnt;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        enable_req = '0;
        hold = '0;

        // 1. reset with sources running
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_outputs", int'({pwr_supply_clk, clk_enabled, clk_fault, busy}), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", int'({pwr_supply_clk, clk_enabled, clk_fault, busy}), 0);

        // 2. single channel, enable requested during a low phase
        wait_src_fall(0);
        enable_req = 3'b001;
        sp = src_clk_in[0];
        op = pwr_supply_clk[0];
        rises = 0; last_rise = -100; rise_k = -1; busy_gate = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) check("t2_busy_in_arm", int'(busy), 1);
            if (src_clk_in[0] && !sp) begin
                rises++;
                last_rise = k;
            end
            if (pwr_supply_clk[0] && !op && rise_k < 0) begin
                rise_k = k;
                check("t2_src_rise_count", rises, 2);
                check("t2_out_latency", k - last_rise, 1);
            end
            if (busy && clk_enabled[0]) busy_gate++;
            sp = src_clk_in[0];
            op = pwr_supply_clk[0];
        end
        check("t2_out_rose", int'(rise_k > 0), 1);
        check("t2_busy_stagger_len", busy_gate, STG);
        check("t2_clk_enabled", int'(clk_enabled), 1);

        // 3. all channels requested at once
        enable_req = 3'b000;
        repeat (30) @(negedge clk);
        check("t3_all_off", int'(clk_enabled), 0);
        enable_req = 3'b111;
        hit = 0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            if (clk_enabled == 3'b111) hit = 1;
        end
        check("t3_all_on", int'(hit), 1);
        @(negedge clk);
        check("t3_gap_0_1", int'(on_time[1] - on_time[0] >= STG + 1), 1);
        check("t3_gap_1_2", int'(on_time[2] - on_time[1] >= STG + 1), 1);
        repeat (25) @(negedge clk);

        // 4. drop channel 1 in the middle of a high phase
        op = pwr_supply_clk[1];
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (pwr_supply_clk[1] && !op) hit = 1;
            op = pwr_supply_clk[1];
        end
        check("t4_found_rise", int'(hit), 1);
        hc = 1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!pwr_supply_clk[1]) break;
            hc++;
            if (hc == 5) enable_req = 3'b101;
        end
        check("t4_last_pulse_width", hc, 10);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pwr_supply_clk[1]) cnt++;
        end
        check("t4_ch1_quiet", cnt, 0);
        check("t4_enabled", int'(clk_enabled), 3'b101);

        // 5. stop source 2 while it is enabled
        wait_src_fall(2);
        hold[2] = 1'b1;
        cnt = 0;
        hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            cnt++;
            if (clk_fault[2]) hit = 1;
        end
        check("t5_fault_latency", cnt, TMO + 1);
        check("t5_gate2_off", int'(clk_enabled[2]), 0);
        check("t5_out2_low", int'(pwr_supply_clk[2]), 0);
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        check("t5_fsm_skips_ch2", bcnt, 0);
        enable_req = 3'b001;
        @(negedge clk);
        check("t5_fault_cleared", int'(clk_fault[2]), 0);
        hold[2] = 1'b0;

        // 6. reset in the middle of a stagger
        enable_req = 3'b011;
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (clk_enabled[1]) hit = 1;
        end
        check("t6_ch1_on", int'(hit), 1);
        repeat (3) @(negedge clk);
        check("t6_busy_in_stagger", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_outputs", int'({pwr_supply_clk, clk_enabled, busy}), 0);
        @(negedge clk);
        rst = 1'b0;
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (clk_enabled != '0) hit = 1;
        end
        check("t6_first_restart", int'(clk_enabled), 3'b001);
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (clk_enabled == 3'b011) hit = 1;
        end
        @(negedge clk);
        check("t6_second_restart", int'(clk_enabled), 3'b011);
        check("t6_restart_gap", int'(on_time[1] - on_time[0] >= STG + 1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
